// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP multiplier between
// NUM_REQ requesters; a tag pipeline steers each product back to its issuer.
`timescale 1ns/1ps
module fpu_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SIZE_DATA   = 32,
    parameter int MUL_LATENCY = 3,
    parameter int TAG_W       = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_hold,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA-1:0]     i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]     i_req_b,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic                             o_mul_valid,
    output logic [SIZE_DATA-1:0]             o_mul_a,
    output logic [SIZE_DATA-1:0]             o_mul_b,
    input  logic [SIZE_DATA-1:0]             i_mul_result,
    output logic [NUM_REQ-1:0]               o_rsp_valid,
    output logic [SIZE_DATA-1:0]             o_rsp_data,
    output logic [$clog2(MUL_LATENCY+2)-1:0] o_inflight,
    output logic                             o_idle
);
    localparam int          CNT_W     = $clog2(MUL_LATENCY + 2);
    localparam int unsigned NUM_REQ_U = NUM_REQ;

    logic [TAG_W-1:0]                   ptr_q, ptr_d;
    logic                               mul_vld_q, mul_vld_d;
    logic [SIZE_DATA-1:0]               mul_a_q, mul_a_d;
    logic [SIZE_DATA-1:0]               mul_b_q, mul_b_d;
    logic [MUL_LATENCY-1:0]             tvld_q, tvld_d;
    logic [MUL_LATENCY-1:0][TAG_W-1:0]  ttag_q, ttag_d;
    logic [NUM_REQ-1:0]                 rsp_vld_q, rsp_vld_d;
    logic [SIZE_DATA-1:0]               rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]                   inflight_q, inflight_d;

    logic                               grant_found;
    logic [TAG_W-1:0]                   grant_idx;
    logic [TAG_W-1:0]                   cand;
    logic                               ret;
    logic [TAG_W-1:0]                   ret_tag;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!i_hold) begin
            for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
                cand = TAG_W'((32'(ptr_q) + i) % NUM_REQ_U);
                if (!grant_found && i_req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        o_req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        ptr_d     = grant_found ? TAG_W'((32'(grant_idx) + 1) % NUM_REQ_U) : ptr_q;
        mul_vld_d = grant_found;
        mul_a_d   = grant_found ? i_req_a[grant_idx*SIZE_DATA +: SIZE_DATA] : mul_a_q;
        mul_b_d   = grant_found ? i_req_b[grant_idx*SIZE_DATA +: SIZE_DATA] : mul_b_q;

        tvld_d    = tvld_q;
        ttag_d    = ttag_q;
        tvld_d[0] = grant_found;
        ttag_d[0] = grant_idx;
        for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
            tvld_d[s] = tvld_q[s-1];
            ttag_d[s] = ttag_q[s-1];
        end

        // Last tag stage lines up with the multiplier output of the same issue.
        ret        = tvld_q[MUL_LATENCY-1];
        ret_tag    = ttag_q[MUL_LATENCY-1];
        rsp_vld_d  = ret ? (NUM_REQ'(1) << ret_tag) : '0;
        rsp_data_d = ret ? i_mul_result : rsp_data_q;

        inflight_d = inflight_q;
        if (grant_found && !ret) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!grant_found && ret) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            mul_vld_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            tvld_q     <= '0;
            ttag_q     <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            mul_vld_q  <= mul_vld_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            tvld_q     <= tvld_d;
            ttag_q     <= ttag_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_mul_valid = mul_vld_q;
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;
    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_inflight  = inflight_q;
    assign o_idle      = ~|i_req_valid && (inflight_q == '0);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter: directed requests push expected results,
// a negedge monitor pops and compares every response strobe.
`timescale 1ns/1ps
module tb_fpu_mul_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int L  = 3;
    localparam int CW = $clog2(L + 2);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a, req_b;
    logic [N-1:0]    req_ready;
    logic            mul_valid;
    logic [W-1:0]    mul_a, mul_b, mul_result;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic [CW-1:0]   inflight;
    logic            idle;

    typedef struct { int id; logic [31:0] data; } exp_t;
    exp_t sbq[$];
    int n_cmp = 0;
    int n_err = 0;

    fpu_mul_arbiter #(.NUM_REQ(N), .SIZE_DATA(W), .MUL_LATENCY(L), .TAG_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready),
        .o_mul_valid(mul_valid), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_result(mul_result),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_inflight(inflight), .o_idle(idle)
    );

    always #5 clk = ~clk;

    // Normal-range single-precision multiply (truncating), enough for exact vectors.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
        return {a[31] ^ b[31], e[7:0], p[45:23]};
    endfunction

    // Multiplier model: L-cycle latency, no reset, garbage when idle.
    logic [31:0] m0 = 32'hDEADBEEF;
    logic [31:0] m1 = 32'hDEADBEEF;
    always @(posedge clk) begin
        m0 <= mul_valid ? fmul(mul_a, mul_b) : 32'hDEADBEEF;
        m1 <= m0;
    end
    assign mul_result = m1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [31:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got valid=%b data=0x%08h expected no response at %0t",
                         rsp_valid, rsp_data, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                check("rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    logic [31:0] rr_a [4];
    logic [31:0] rr_b [4];
    logic [31:0] rr_p [4];
    logic [31:0] h_a  [3];
    logic [31:0] h_b  [3];
    logic [31:0] h_p  [3];

    initial begin
        rr_a = '{32'h40000000, 32'hBF800000, 32'h3FC00000, 32'h3F000000};
        rr_b = '{32'h40400000, 32'h40A00000, 32'h40800000, 32'h41000000};
        rr_p = '{32'h40C00000, 32'hC0A00000, 32'h40C00000, 32'h40800000};
        h_a  = '{32'h40000000, 32'h40400000, 32'h40000000};
        h_b  = '{32'h40400000, 32'h40400000, 32'h40000000};
        h_p  = '{32'h40C00000, 32'h41100000, 32'h40800000};

        rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        @(negedge clk);
        check("rst_mul_valid", 32'(mul_valid), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;

        // Single op: 2.0 * 3.0
        set_ops(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'h1);
        push(0, 32'h40C00000);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_mul_valid", 32'(mul_valid), 1);
        check("single_mul_a", mul_a, 32'h40000000);
        check("single_mul_b", mul_b, 32'h40400000);
        check("single_inflight", 32'(inflight), 1);
        repeat (4) tick();
        @(negedge clk);
        check("single_inflight_end", 32'(inflight), 0);
        check("single_idle_end", 32'(idle), 1);

        // Reset to bring the pointer back to 0, then all four requesting.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_ops(k, rr_a[k], rr_b[k]);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1) << (i % 4));
            push(i % 4, rr_p[i % 4]);
            tick();
        end
        req_valid = '0;
        repeat (5) tick();

        // Fairness: req1 alone moves pointer to 2, then req1/req3 alternate.
        req_valid = 4'b0010;
        @(negedge clk);
        check("fair_setup", 32'(req_ready), 32'h2);
        push(1, rr_p[1]);
        tick();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fair_grant", 32'(req_ready), (i % 2 == 0) ? 32'h8 : 32'h2);
            push((i % 2 == 0) ? 3 : 1, rr_p[(i % 2 == 0) ? 3 : 1]);
            tick();
        end
        req_valid = '0;
        repeat (5) tick();

        // Hold while req0 streams.
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_ops(0, h_a[i], h_b[i]);
            @(negedge clk);
            check("hold_stream_ready", 32'(req_ready), 32'h1);
            push(0, h_p[i]);
            tick();
        end
        hold = 1'b1;
        @(negedge clk);
        check("hold_ready0", 32'(req_ready), 0);
        check("hold_inflight3", 32'(inflight), 3);
        tick();
        @(negedge clk);
        check("hold_ready1", 32'(req_ready), 0);
        check("hold_mul_valid", 32'(mul_valid), 0);
        check("hold_inflight2", 32'(inflight), 2);
        tick();
        hold = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("hold_inflight1", 32'(inflight), 1);
        repeat (4) tick();

        // Reset with two ops in flight (req1 then req2, pointer ends at 3).
        for (int k = 0; k < 4; k++) set_ops(k, rr_a[k], rr_b[k]);
        req_valid = 4'b0110;
        @(negedge clk);
        check("rstmid_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100;
        @(negedge clk);
        check("rstmid_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_mul_valid", 32'(mul_valid), 0);
        check("rstmid_mul_a", mul_a, 0);
        check("rstmid_inflight", 32'(inflight), 0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 0);
        check("rstmid_idle", 32'(idle), 1);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        req_valid = 4'b1111;
        @(negedge clk);
        check("rstmid_first_grant", 32'(req_ready), 32'h1);
        push(0, rr_p[0]);
        tick();
        req_valid = '0;
        repeat (5) tick();

        // Continuous req0: simultaneous issue and return.
        set_ops(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stream_ready", 32'(req_ready), 32'h1);
            if (i >= 3) check("stream_inflight", 32'(inflight), 3);
            if (i >= 4) check("stream_rsp_valid", 32'(rsp_valid), 32'h1);
            push(0, 32'h40C00000);
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        check("end_inflight", 32'(inflight), 0);
        check("end_idle", 32'(idle), 1);
        check("end_rsp_data_held", rsp_data, 32'h40C00000);
        check("end_queue_empty", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Shares one pipelined FPU multiplier (fixed latency, no stall) between NUM_REQ requesters, e.g. the butterfly twiddle-multiply lanes of the 8-point FFT.
- Round-robin arbitrates issue slots and drives operands into the multiplier.
- Tracks each issued operation with a tag pipeline and routes every result back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE_DATA, 32, IEEE-754 single-precision operand/result width.
- MUL_LATENCY, 3, cycles from o_mul_valid to the matching i_mul_result (>=1).
- TAG_W, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hold  in  1  when 1, no new issue; in-flight operations continue.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_a  in  NUM_REQ*SIZE_DATA  operand A; requester k occupies bits [k*SIZE_DATA +: SIZE_DATA].
- i_req_b  in  NUM_REQ*SIZE_DATA  operand B, same packing as i_req_a.
- o_req_ready  out  NUM_REQ  one-hot grant; combinational.
- o_mul_valid  out  1  operands valid to the multiplier; registered.
- o_mul_a  out  SIZE_DATA  operand A to the multiplier; registered.
- o_mul_b  out  SIZE_DATA  operand B to the multiplier; registered.
- i_mul_result  in  SIZE_DATA  multiplier product.
- o_rsp_valid  out  NUM_REQ  one-hot result strobe; registered.
- o_rsp_data  out  SIZE_DATA  result, shared by all requesters; registered.
- o_inflight  out  clog2(MUL_LATENCY+2)  number of issued operations not yet returned.
- o_idle  out  1  1 when no i_req_valid is set and o_inflight==0.

Behaviour:
- Reset is asynchronous. While i_rst_n=0 the following are held:
  - o_mul_valid=0, o_mul_a=0, o_mul_b=0.
  - o_rsp_valid=0, o_rsp_data=0.
  - o_inflight=0.
  - Round-robin pointer=0; tag pipeline valid bits all 0.
- o_idle is combinational and therefore reads 1 during reset whenever no request is asserted.
- Arbitration (combinational):
  - If i_hold=0, o_req_ready is one-hot on the first requester with i_req_valid=1, searching from pointer upward and wrapping modulo NUM_REQ.
  - If i_hold=1 or no request is valid, o_req_ready=0.
- Handshake:
  - An operation transfers when i_req_valid[k] & o_req_ready[k] is high at a rising edge.
  - A requester must hold its valid and operands stable until it is granted.
  - Maximum throughput is one issue per cycle.
- Pointer update: on a transfer from requester k, pointer <= (k+1) mod NUM_REQ. Otherwise the pointer is unchanged.
- Issue (at the transfer edge):
  - o_mul_valid<=1 and o_mul_a/o_mul_b<=granted operands.
  - The tag pipeline stage 0 is loaded with {valid=1, tag=k}.
- Non-issue cycle: o_mul_valid<=0; operand registers hold their previous values.
- Tag pipeline:
  - MUL_LATENCY stages, each shifting every cycle unconditionally.
  - The last stage aligns with i_mul_result, i.e. the result of an issue at edge t is sampled at edge t+MUL_LATENCY.
- Return:
  - When the last stage is valid with tag j, at that edge o_rsp_valid<=one-hot(j) and o_rsp_data<=i_mul_result.
  - Otherwise o_rsp_valid<=0 and o_rsp_data holds its value.
  - End-to-end: a request granted at edge t produces o_rsp_valid[k]=1 in the cycle after edge t+MUL_LATENCY, for one cycle.
- There is no response back-pressure. Requesters must accept the result in the strobe cycle.
- o_inflight:
  - +1 on issue, -1 on return, unchanged when both occur in the same cycle.
  - Never exceeds MUL_LATENCY+1.
- Boundary conditions:
  - A single requester streaming every cycle is granted every cycle; the pointer wraps but the search returns to it.
  - All requesters valid: grant order k, k+1, … mod NUM_REQ; each granted exactly once per NUM_REQ cycles.
  - i_hold asserted mid-stream: issue stops the same cycle; pending returns still complete in order.
  - Reset mid-operation: all in-flight tags are discarded. Multiplier outputs belonging to pre-reset issues never produce o_rsp_valid.
  - Results return strictly in issue order.
  - X on i_mul_result when no tag is valid must not propagate to o_rsp_data.

Test Plan:
- Single op, MUL_LATENCY=3:
  - Stimulus: reset, then req0 a=0x40000000 (2.0), b=0x40400000 (3.0); a behavioural multiplier model drives i_mul_result.
  - Required: o_req_ready=0001 in the request cycle; o_mul_valid one cycle later; o_rsp_valid=0001 with o_rsp_data=0x40C00000 (6.0) in the cycle after edge t+3; o_inflight returns to 0 and o_idle=1.
- Round-robin with all four requesters valid for 8 cycles, pointer starting at 0:
  - Required: grant sequence 0,1,2,3,0,1,2,3.
  - Required: responses arrive back-to-back in the same order, each carrying that requester's product (e.g. req2 1.5×4.0 -> 0x40C00000).
- Fairness after a skip:
  - Stimulus: only req1 and req3 valid, pointer=2.
  - Required: grants alternate 3,1,3,1; req0 is never granted.
- i_hold:
  - Stimulus: i_hold pulsed high for 2 cycles while req0 streams.
  - Required: o_req_ready=0 and o_mul_valid=0 in the following cycle(s); the 3 in-flight results still return; o_inflight sequence 3,2,1 is visible.
- Reset mid-operation:
  - Stimulus: drop i_rst_n with 2 operations in flight.
  - Required: all outputs 0 immediately (asynchronous); no o_rsp_valid after release even though the multiplier still outputs old products; the first post-reset grant goes to req0.
- Simultaneous issue and return:
  - Stimulus: req0 streaming continuously.
  - Required: steady-state o_inflight holds at 3; o_rsp_valid=0001 every cycle; no result dropped or duplicated.
